// File: rtl/game_ctrl_if.sv
// Port bundle for game_ctrl: per-frame player controls in, complete scene layout out.
// There is no valid/ready pair here: frame_tick is a one-cycle strobe that qualifies
// motion, btn is level-sampled every cycle, and every output is a registered level.
interface game_ctrl_if;
    logic       frame_tick;
    logic       btn;
    logic [9:0] rnd;
    logic [3:0] state;
    logic [9:0] man_x;
    logic [9:0] man_y;
    logic [9:0] man_tall;
    logic [9:0] stage_x [0:1];
    logic [9:0] stage_w [0:1];
    logic [1:0] stage_color [0:1];
    logic [9:0] stage_y2;
    logic [7:0] score;

    modport master (
        output frame_tick, btn, rnd,
        input  state, man_x, man_y, man_tall, stage_x, stage_w, stage_color, stage_y2, score
    );

    modport slave (
        input  frame_tick, btn, rnd,
        output state, man_x, man_y, man_tall, stage_x, stage_w, stage_color, stage_y2, score
    );
endinterface

// File: rtl/game_ctrl.sv
// Jump-game controller: charge with the button, fly a ballistic arc, land, scroll the
// scene left and drop in a freshly randomised target stage.
module game_ctrl (
    input  logic       clk,
    input  logic       rst,
    game_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        START  = 4'd0,
        IDLE   = 4'd1,
        CHARGE = 4'd2,
        JUMP   = 4'd3,
        LAND   = 4'd4,
        SCROLL = 4'd5,
        DROP   = 4'd6,
        DEAD   = 4'd7
    } state_t;

    localparam logic [9:0] HOME_X   = 10'd200;
    localparam logic [9:0] GROUND_Y = 10'd500;
    localparam logic [9:0] BODY     = 10'd40;
    localparam logic [9:0] MAX_X    = 10'd799;

    state_t            st;
    logic              btn_prev;
    logic [7:0]        power;
    logic signed [5:0] vy;
    logic [4:0]        dx;
    logic [4:0]        frame_cnt;

    logic        rise;
    logic        load_init;
    logic [7:0]  power_inc;
    logic [10:0] jump_x;
    logic [9:0]  gap0;
    logic [9:0]  gap1;
    logic [9:0]  span;
    logic [9:0]  step;

    assign bus.state = st;
    assign rise      = bus.btn & ~btn_prev;
    // Reset, an illegal code, and restarting from DEAD all rebuild the same layout.
    assign load_init = ~rst | st[3] | ((st == DEAD) & rise);
    assign power_inc = (power > 8'd253) ? 8'hFF : power + 8'd2;
    assign jump_x    = {1'b0, bus.man_x} + {6'b0, dx};
    assign gap0      = (bus.man_x >= bus.stage_x[0]) ? bus.man_x - bus.stage_x[0]
                                                     : bus.stage_x[0] - bus.man_x;
    assign gap1      = (bus.man_x >= bus.stage_x[1]) ? bus.man_x - bus.stage_x[1]
                                                     : bus.stage_x[1] - bus.man_x;
    assign span      = bus.stage_x[1] - HOME_X;
    assign step      = (span > 10'd8) ? 10'd8 : span;

    always_ff @(posedge clk) begin
        btn_prev <= rst ? bus.btn : 1'b1;
        if (load_init) begin
            st                 <= (rst && st == DEAD) ? IDLE : START;
            bus.man_x          <= HOME_X;
            bus.man_y          <= GROUND_Y;
            bus.man_tall       <= BODY;
            bus.stage_x[0]     <= HOME_X;
            bus.stage_w[0]     <= 10'd50;
            bus.stage_color[0] <= 2'b00;
            bus.stage_x[1]     <= 10'd500;
            bus.stage_w[1]     <= 10'd40;
            bus.stage_color[1] <= 2'b11;
            bus.stage_y2       <= GROUND_Y;
            bus.score          <= 8'd0;
            power              <= 8'd0;
            vy                 <= 6'sd0;
            dx                 <= 5'd0;
            frame_cnt          <= 5'd0;
        end else begin
            case (st)
                START: if (rise) st <= IDLE;
                IDLE: begin
                    if (rise) begin
                        st    <= CHARGE;
                        power <= 8'd0;
                    end
                end
                CHARGE: begin
                    // Release wins over a coincident tick: the last frame adds no power.
                    if (!bus.btn) begin
                        st           <= JUMP;
                        bus.man_tall <= BODY;
                        vy           <= 6'sd12;
                        dx           <= power[7:3];
                        frame_cnt    <= 5'd0;
                    end else if (bus.frame_tick) begin
                        power        <= power_inc;
                        bus.man_tall <= BODY - {6'd0, power_inc[7:4]};
                    end
                end
                JUMP: begin
                    if (bus.frame_tick) begin
                        bus.man_y <= bus.man_y - {{4{vy[5]}}, vy};
                        vy        <= vy - 6'sd1;
                        bus.man_x <= (jump_x > 11'd799) ? MAX_X : jump_x[9:0];
                        frame_cnt <= frame_cnt + 5'd1;
                        if (frame_cnt == 5'd24) st <= LAND;
                    end
                end
                LAND: begin
                    if (gap1 <= bus.stage_w[1]) begin
                        bus.score <= (bus.score == 8'hFF) ? 8'hFF : bus.score + 8'd1;
                        st        <= SCROLL;
                    end else if (gap0 <= bus.stage_w[0]) begin
                        st <= IDLE;
                    end else begin
                        st <= DEAD;
                    end
                end
                SCROLL: begin
                    // Target has reached home: it becomes the current stage and a new one spawns.
                    if (bus.stage_x[1] == HOME_X) begin
                        bus.stage_x[0]     <= bus.stage_x[1];
                        bus.stage_w[0]     <= bus.stage_w[1];
                        bus.stage_color[0] <= bus.stage_color[1];
                        bus.stage_x[1]     <= 10'd450 + {2'b00, bus.rnd[7:0]};
                        bus.stage_w[1]     <= 10'd30 + {5'b00000, bus.rnd[4:0]};
                        bus.stage_color[1] <= bus.rnd[9:8];
                        bus.stage_y2       <= 10'd0;
                        st                 <= DROP;
                    end else if (bus.frame_tick) begin
                        bus.stage_x[1] <= bus.stage_x[1] - step;
                        bus.stage_x[0] <= (bus.stage_x[0] > step) ? bus.stage_x[0] - step : 10'd0;
                        bus.man_x      <= (bus.man_x > step) ? bus.man_x - step : 10'd0;
                    end
                end
                DROP: begin
                    if (bus.frame_tick) begin
                        bus.stage_y2 <= bus.stage_y2 + 10'd20;
                        if (bus.stage_y2 == 10'd480) st <= IDLE;
                    end
                end
                DEAD: ;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: a closed-form scene model checked every cycle,
// plus hand-computed checkpoints along the scripted games.
module tb_game_ctrl;
    logic clk;
    logic rst;
    game_ctrl_if bus ();

    game_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Scene model: plain integers, motion expressed as closed forms of ticks elapsed.
    int m_state, m_x, m_y, m_tall, m_y2, m_score, m_power;
    int m_sx [2];
    int m_sw [2];
    int m_sc [2];
    int m_n, m_k, m_dx, m_jx, m_x1s, m_x0s, m_mxs;
    bit m_pb;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic model_init();
        m_x = 200; m_y = 500; m_tall = 40;
        m_sx[0] = 200; m_sw[0] = 50; m_sc[0] = 0;
        m_sx[1] = 500; m_sw[1] = 40; m_sc[1] = 3;
        m_y2 = 500; m_score = 0; m_power = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit b, t, rise;
        int r, d;
        b = bus.btn;
        t = bus.frame_tick;
        rise = b && !m_pb;
        if (!rst) begin
            model_init();
            m_state = 0;
            m_pb = 1'b1;
        end else begin
            m_pb = b;
            case (m_state)
                0: if (rise) m_state = 1;
                1: if (rise) begin m_state = 2; m_n = 0; m_power = 0; end
                2: begin
                    if (!b) begin
                        m_state = 3; m_dx = m_power / 8; m_jx = m_x; m_k = 0; m_tall = 40;
                    end else if (t) begin
                        m_n++;
                        m_power = imin(2 * m_n, 255);
                        m_tall = 40 - m_power / 16;
                    end
                end
                3: begin
                    if (t) begin
                        m_k++;
                        m_y = 500 - (12 * m_k - m_k * (m_k - 1) / 2);
                        m_x = imin(m_jx + m_k * m_dx, 799);
                        if (m_k == 25) m_state = 4;
                    end
                end
                4: begin
                    if (iabs(m_x - m_sx[1]) <= m_sw[1]) begin
                        m_score = imin(m_score + 1, 255);
                        m_state = 5; m_k = 0;
                        m_x1s = m_sx[1]; m_x0s = m_sx[0]; m_mxs = m_x;
                    end else if (iabs(m_x - m_sx[0]) <= m_sw[0]) begin
                        m_state = 1;
                    end else begin
                        m_state = 7;
                    end
                end
                5: begin
                    if (m_sx[1] == 200) begin
                        r = int'(bus.rnd);
                        m_sx[0] = m_sx[1]; m_sw[0] = m_sw[1]; m_sc[0] = m_sc[1];
                        m_sx[1] = 450 + (r % 256);
                        m_sw[1] = 30 + (r % 32);
                        m_sc[1] = r / 256;
                        m_y2 = 0; m_state = 6; m_k = 0;
                    end else if (t) begin
                        m_k++;
                        d = imin(8 * m_k, m_x1s - 200);
                        m_sx[1] = m_x1s - d;
                        m_sx[0] = imax(0, m_x0s - d);
                        m_x = imax(0, m_mxs - d);
                    end
                end
                6: begin
                    if (t) begin
                        m_k++;
                        m_y2 = 20 * m_k;
                        if (m_y2 >= 500) m_state = 1;
                    end
                end
                7: if (rise) begin model_init(); m_state = 1; end
                default: begin model_init(); m_state = 0; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state",    int'(bus.state),          m_state);
            chk("man_x",    int'(bus.man_x),          m_x);
            chk("man_y",    int'(bus.man_y),          m_y);
            chk("man_tall", int'(bus.man_tall),       m_tall);
            chk("stage_x0", int'(bus.stage_x[0]),     m_sx[0]);
            chk("stage_w0", int'(bus.stage_w[0]),     m_sw[0]);
            chk("color0",   int'(bus.stage_color[0]), m_sc[0]);
            chk("stage_x1", int'(bus.stage_x[1]),     m_sx[1]);
            chk("stage_w1", int'(bus.stage_w[1]),     m_sw[1]);
            chk("color1",   int'(bus.stage_color[1]), m_sc[1]);
            chk("stage_y2", int'(bus.stage_y2),       m_y2);
            chk("score",    int'(bus.score),          m_score);
        end
    end

    task automatic cyc(input logic b, input logic t);
        bus.btn = b;
        bus.frame_tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n, input logic b);
        for (int i = 0; i < n; i++) begin
            cyc(b, 1'b1);
            cyc(b, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(1'b0, 1'b1);
        rst = 1'b1;
        cyc(1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        bus.btn = 1'b0;
        bus.frame_tick = 1'b0;
        bus.rnd = 10'h3FF;

        // Reset with a coincident tick; layout must be the initial one.
        cyc(1'b0, 1'b1);
        chk_en = 1'b1;
        cyc(1'b0, 1'b1);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_man_x", int'(bus.man_x), 200);
        chk("rst_x1", int'(bus.stage_x[1]), 500);
        chk("rst_color1", int'(bus.stage_color[1]), 3);
        rst = 1'b1;
        cyc(1'b0, 1'b1);

        // Press, release, press, 48 ticks of charge, release and fly onto stage 1.
        cyc(1'b1, 1'b1);
        chk("start_to_idle", int'(bus.state), 1);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        chk("charge_enter_tall", int'(bus.man_tall), 40);
        frames(48, 1'b1);
        chk("charge48_tall", int'(bus.man_tall), 34);
        cyc(1'b0, 1'b1);
        chk("jump_enter", int'(bus.state), 3);
        frames(1, 1'b0);
        chk("jump1_y", int'(bus.man_y), 488);
        chk("jump1_x", int'(bus.man_x), 212);
        frames(24, 1'b0);
        chk("land_state", int'(bus.state), 5);
        chk("land_x", int'(bus.man_x), 500);
        chk("land_y", int'(bus.man_y), 500);
        chk("land_score", int'(bus.score), 1);

        // Scroll 300 pixels: 37 steps of 8 then a final step of 4.
        frames(37, 1'b0);
        chk("scroll37_x1", int'(bus.stage_x[1]), 204);
        cyc(1'b0, 1'b1);
        chk("scroll_end_x1", int'(bus.stage_x[1]), 200);
        chk("scroll_end_x0", int'(bus.stage_x[0]), 0);
        chk("scroll_end_man", int'(bus.man_x), 200);
        cyc(1'b0, 1'b0);
        chk("spawn_state", int'(bus.state), 6);
        chk("spawn_x0", int'(bus.stage_x[0]), 200);
        chk("spawn_w0", int'(bus.stage_w[0]), 40);
        chk("spawn_x1", int'(bus.stage_x[1]), 705);
        chk("spawn_w1", int'(bus.stage_w[1]), 61);
        chk("spawn_y2", int'(bus.stage_y2), 0);
        frames(24, 1'b0);
        chk("drop24_y2", int'(bus.stage_y2), 480);
        cyc(1'b0, 1'b1);
        chk("drop_done", int'(bus.state), 1);

        // Second landing: dx=20 reaches x=700 on the stage at 705, then a 505-pixel scroll.
        bus.rnd = 10'h0A5;
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        frames(80, 1'b1);
        chk("charge80_tall", int'(bus.man_tall), 30);
        cyc(1'b0, 1'b0);
        frames(25, 1'b0);
        chk("land2_x", int'(bus.man_x), 700);
        chk("land2_score", int'(bus.score), 2);
        frames(64, 1'b0);
        chk("spawn2_x1", int'(bus.stage_x[1]), 615);
        chk("spawn2_w1", int'(bus.stage_w[1]), 35);
        chk("spawn2_color1", int'(bus.stage_color[1]), 0);
        chk("spawn2_man", int'(bus.man_x), 195);
        frames(25, 1'b0);

        // Tiny hop: dx=0, lands back on the current stage.
        cyc(1'b1, 1'b0);
        frames(2, 1'b1);
        cyc(1'b0, 1'b0);
        frames(25, 1'b0);
        chk("hop_state", int'(bus.state), 1);
        chk("hop_score", int'(bus.score), 2);

        // From the initial layout, 16 ticks: dx=4 lands at 300, between stages.
        do_reset();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        frames(16, 1'b1);
        cyc(1'b0, 1'b0);
        frames(25, 1'b0);
        chk("dead_state", int'(bus.state), 7);
        chk("dead_x", int'(bus.man_x), 300);
        frames(3, 1'b0);
        chk("dead_hold", int'(bus.man_x), 300);
        cyc(1'b1, 1'b1);
        chk("restart_state", int'(bus.state), 1);
        chk("restart_x", int'(bus.man_x), 200);
        chk("restart_score", int'(bus.score), 0);

        // Two ticks from the initial layout: dx=0, stays on stage 0.
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        frames(2, 1'b1);
        cyc(1'b0, 1'b0);
        frames(25, 1'b0);
        chk("small_hop_state", int'(bus.state), 1);
        chk("small_hop_x", int'(bus.man_x), 200);

        // Over-charge: power saturates, x clamps at the right edge.
        cyc(1'b1, 1'b0);
        frames(140, 1'b1);
        chk("sat_tall", int'(bus.man_tall), 25);
        cyc(1'b0, 1'b0);
        frames(25, 1'b0);
        chk("clamp_x", int'(bus.man_x), 799);
        chk("clamp_dead", int'(bus.state), 7);

        // Reset mid-jump on a tick cycle.
        do_reset();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        frames(10, 1'b1);
        cyc(1'b0, 1'b0);
        frames(5, 1'b0);
        chk("midjump_y", int'(bus.man_y), 450);
        rst = 1'b0;
        cyc(1'b0, 1'b1);
        chk("abort_state", int'(bus.state), 0);
        chk("abort_y", int'(bus.man_y), 500);
        chk("abort_x", int'(bus.man_x), 200);
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        frames(3, 1'b0);
        chk("post_abort_x", int'(bus.man_x), 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
